lsu_mem_ctrl: RTL and testbench

- Load/store unit sitting directly upstream of the DPI-backed data RAM port.
- Accepts one load or store request from the execute stage over a valid/ready handshake.
- Converts the request into the RAM's word-wide write data and byte mask.
- Waits out the RAM's one-cycle registered read, then returns aligned, sign/zero-extended data with an error flag.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 48 ++++
 rtl/lsu_mem_ctrl.sv | 112 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states and
// the request legality check.
package lsu_pkg;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } lsu_state_e;

   // Illegal size always errors; misalignment only when checking is enabled.
   function automatic logic lsu_req_err(input logic [1:0] size,
                                        input logic [1:0] offset,
                                        input logic       align_check);
      logic err;
      case (size)
         SIZE_B:  err = 1'b0;
         SIZE_H:  err = align_check & offset[0];
         SIZE_W:  err = align_check & (offset != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store data replication and byte mask, plus
// load-data shift and sign/zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  mask_o,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;
   logic [3:0]  mask_base;

   always_comb begin
      wdata_o   = wdata_i;
      mask_base = 4'b0000;
      rdata_o   = '0;
      // Lanes above byte 3 shift in as zero before extension.
      shifted   = rdata_i >> {offset_i, 3'b000};
      case (size_i)
         SIZE_B: begin
            wdata_o   = {4{wdata_i[7:0]}};
            mask_base = 4'b0001;
            rdata_o   = unsigned_i ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
         end
         SIZE_H: begin
            wdata_o   = {2{wdata_i[15:0]}};
            mask_base = 4'b0011;
            rdata_o   = unsigned_i ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
         end
         SIZE_W: begin
            wdata_o   = wdata_i;
            mask_base = 4'b1111;
            rdata_o   = shifted;
         end
         default: ;
      endcase
      mask_o = mask_base << offset_i;
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit in front of the data RAM: accepts one request, issues a
// single RAM access and returns an aligned, extended response.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic            mem_valid,
   output logic            mem_write_enable,
   output logic [XLEN-1:0] mem_write_addr,
   output logic [XLEN-1:0] mem_read_addr,
   output logic [XLEN-1:0] mem_write_data,
   output logic [3:0]      mem_write_mask,
   input  logic [XLEN-1:0] mem_read_data
);

   if (XLEN != 32) begin : gen_xlen_chk
      $error("lsu_mem_ctrl supports XLEN == 32 only");
   end

   lsu_state_e  state_q;
   logic        write_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        req_err;
   logic        issue;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_mask;
   logic [31:0] lane_rdata;

   assign req_err = lsu_req_err(req_size, req_addr[1:0], ALIGN_CHECK);

   lsu_lane_align u_lane_align (
      .size_i     (size_q),
      .offset_i   (addr_q[1:0]),
      .unsigned_i (uns_q),
      .wdata_i    (wdata_q),
      .rdata_i    (mem_read_data),
      .wdata_o    (lane_wdata),
      .mask_o     (lane_mask),
      .rdata_o    (lane_rdata)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         write_q <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  write_q <= req_write;
                  size_q  <= req_size;
                  uns_q   <= req_unsigned;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  err_q   <= req_err;
                  state_q <= req_err ? StResp : StIssue;
               end
            end
            StIssue: state_q <= write_q ? StResp : StWait;
            StWait: begin
               rdata_q <= lane_rdata;
               err_q   <= 1'b0;
               state_q <= StResp;
            end
            StResp: begin
               if (resp_ready) state_q <= StIdle;
            end
         endcase
      end
   end

   assign issue            = (state_q == StIssue);
   assign req_ready        = (state_q == StIdle);
   assign resp_valid       = (state_q == StResp);
   assign resp_rdata       = rdata_q;
   assign resp_err         = err_q;
   assign mem_valid        = issue;
   assign mem_write_enable = issue & write_q;
   assign mem_write_addr   = issue ? {addr_q[31:2], 2'b00} : '0;
   assign mem_read_addr    = mem_write_addr;
   assign mem_write_data   = issue ? lane_wdata : '0;
   assign mem_write_mask   = issue ? lane_mask : 4'b0000;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl with a byte-array reference model and a
// small registered-read RAM behind the memory port.
module tb_lsu_mem_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_valid;
   logic        mem_write_enable;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_read_addr;
   logic [31:0] mem_write_data;
   logic [3:0]  mem_write_mask;
   logic [31:0] mem_read_data;

   lsu_mem_ctrl #(
      .XLEN        (32),
      .ALIGN_CHECK (1'b1)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_write        (req_write),
      .req_size         (req_size),
      .req_unsigned     (req_unsigned),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_rdata       (resp_rdata),
      .resp_err         (resp_err),
      .mem_valid        (mem_valid),
      .mem_write_enable (mem_write_enable),
      .mem_write_addr   (mem_write_addr),
      .mem_read_addr    (mem_read_addr),
      .mem_write_data   (mem_write_data),
      .mem_write_mask   (mem_write_mask),
      .mem_read_data    (mem_read_data)
   );

   always #5 clock = ~clock;

   // RAM: 16 words, data valid the cycle after mem_valid.
   logic [31:0] ram [16];
   always @(posedge clock) begin
      if (mem_valid) begin
         if (mem_write_enable) begin
            for (int k = 0; k < 4; k++) begin
               if (mem_write_mask[k]) ram[mem_write_addr[5:2]][8*k +: 8] <= mem_write_data[8*k +: 8];
            end
         end
         mem_read_data <= ram[mem_read_addr[5:2]];
      end
   end

   logic [7:0]  shadow [64];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] last_wdata;
   logic [3:0]  last_mask;
   logic [31:0] last_addr;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
      return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
   endfunction

   function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
      int unsigned n = 1 << size;
      logic [31:0] d = '0;
      for (int k = 0; k < 4; k++) d[8*k +: 8] = wdata[8*(k % n) +: 8];
      return d;
   endfunction

   function automatic logic [3:0] model_mask(input logic [1:0] size, input logic [31:0] addr);
      int unsigned n = 1 << size;
      int unsigned o = addr % 4;
      logic [3:0] m = '0;
      for (int i = 0; i < n; i++) if (o + i < 4) m[o+i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] addr);
      int unsigned n = 1 << size;
      int unsigned o = addr % 4;
      int unsigned base = addr % 64 - o;
      longint v = 0;
      for (int i = 0; i < n; i++) if (o + i < 4) v = v | (longint'(shadow[base+o+i]) << (8*i));
      if (!uns && v[8*n-1]) v = v - (longint'(1) << (8*n));
      return v[31:0];
   endfunction

   task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      int unsigned n = 1 << size;
      int unsigned o = addr % 4;
      int unsigned base = addr % 64 - o;
      for (int lane = 0; lane < 4; lane++) begin
         if (lane >= o && lane < o + n) shadow[base+lane] = wdata[8*(lane % n) +: 8];
      end
   endtask

   task automatic run_req(input logic wr, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int bp,
                          output logic [31:0] rd_o);
      bit          err = model_err(size, addr);
      int          lat_exp = err ? 1 : (wr ? 2 : 3);
      logic [31:0] exp_rd = (err || wr) ? 32'h0 : model_load(size, uns, addr);
      logic [31:0] held;
      int          cyc;
      int          n_issue = 0;
      for (int i = 0; i < 20 && !req_ready; i++) begin
         @(posedge clock);
         #1;
      end
      check_eq("req_ready_idle", req_ready, 1);
      req_write = wr; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      cyc = 1;
      while (!resp_valid && cyc <= 8) begin
         check_eq("req_ready_busy", req_ready, 0);
         if (mem_valid) begin
            n_issue++;
            last_wdata = mem_write_data; last_mask = mem_write_mask; last_addr = mem_write_addr;
            check_eq("mem_we", mem_write_enable, wr);
            check_eq("mem_waddr", mem_write_addr, {addr[31:2], 2'b00});
            check_eq("mem_raddr", mem_read_addr, {addr[31:2], 2'b00});
            if (wr) begin
               check_eq("mem_wdata", mem_write_data, model_wdata(size, wdata));
               check_eq("mem_mask", mem_write_mask, model_mask(size, addr));
            end
         end else begin
            check_eq("mem_idle_zero", {mem_write_enable, mem_write_mask, |mem_write_addr,
                                       |mem_read_addr, |mem_write_data}, 0);
         end
         resp_ready = 1'($urandom_range(0, 1));
         @(posedge clock);
         #1;
         cyc++;
      end
      resp_ready = 1'b0;
      check_eq("latency", cyc, lat_exp);
      check_eq("mem_valid_count", n_issue, err ? 0 : 1);
      check_eq("resp_rdata", resp_rdata, exp_rd);
      check_eq("resp_err", resp_err, err);
      rd_o = resp_rdata;
      if (!err && wr) model_store(size, addr, wdata);
      if (!resp_valid) return;
      held = resp_rdata;
      for (int i = 0; i < bp; i++) begin
         req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom; req_size = 2'd0;
         @(posedge clock);
         #1;
         check_eq("bp_hold", {resp_valid, req_ready, mem_valid, resp_err}, {1'b1, 1'b0, 1'b0, err});
         check_eq("bp_rdata", resp_rdata, held);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      req_valid = 1'b0;
      check_eq("resp_done", {resp_valid, req_ready, mem_valid}, {1'b0, 1'b1, 1'b0});
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  sz;
      logic [31:0] a;
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_ctrl", {req_ready, resp_valid, resp_err, mem_valid, mem_write_enable}, 5'b10000);
      check_eq("rst_data", resp_rdata | mem_write_addr | mem_write_data | {28'h0, mem_write_mask}, 0);
      reset = 1'b1;

      for (int w = 0; w < 16; w++) run_req(1'b1, 2'd2, 1'b0, 32'h8000_0000 + 4 * w, $urandom, 0, rd);

      run_req(1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 0, rd);
      check_eq("dir_sw_mask", last_mask, 4'hF);
      check_eq("dir_sw_addr", last_addr, 32'h8000_0004);
      run_req(1'b1, 2'd0, 1'b0, 32'h8000_0003, 32'h0000_005A, 0, rd);
      check_eq("dir_sb_data", last_wdata, 32'h5A5A_5A5A);
      check_eq("dir_sb_mask", last_mask, 4'b1000);
      check_eq("dir_sb_addr", last_addr, 32'h8000_0000);
      run_req(1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'h1234_F600, 0, rd);
      run_req(1'b0, 2'd0, 1'b0, 32'h8000_0001, 32'h0, 0, rd);
      check_eq("dir_lb", rd, 32'hFFFF_FFF6);
      run_req(1'b0, 2'd0, 1'b1, 32'h8000_0001, 32'h0, 0, rd);
      check_eq("dir_lbu", rd, 32'h0000_00F6);
      run_req(1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'h8001_7FFF, 0, rd);
      run_req(1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 5, rd);
      check_eq("dir_lh", rd, 32'hFFFF_8001);
      run_req(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0, 0, rd);
      check_eq("dir_lw_mis", rd, 32'h0);

      // Reset while a load sits in WAIT.
      req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h8000_0008;
      req_valid = 1'b1;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      check_eq("pre_rst_wait", {req_ready, resp_valid, mem_valid}, 3'b000);
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_rst_ctrl", {req_ready, resp_valid, resp_err, mem_valid}, 4'b1000);
      check_eq("async_rst_data", resp_rdata | mem_write_addr, 0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            seen = seen | resp_valid;
         end
         check_eq("no_resp_after_rst", seen, 0);
      end
      run_req(1'b0, 2'd2, 1'b0, 32'h8000_0008, 32'h0, 1, rd);

      for (int t = 0; t < 250; t++) begin
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a = 32'h8000_0000 | 32'($urandom_range(0, 63));
         if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 1);
         run_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 3), rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
